puf_ec_ctrl: RTL

Parametrised error-correction controller for the RO-PUF key path and successor to the single-codeword corrector. It captures NBLK codewords of raw response plus helper data and streams each (response XOR helper) codeword BITS at a time to an external BCH decoder. It collects the returned error pattern and outputs the corrected response, error weight and a failure flag. Unlike the previous block, it handles several codewords per request, has a reset, counts errors, checks each codeword against the correction capability T, and times out a silent decoder.

---
 rtl/puf_ec_pkg.sv | 24 ++
 rtl/ec_beat_popcount.sv | 19 +
 rtl/puf_ec_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/puf_ec_pkg.sv
// Shared types and sizing helpers for the PUF error-correction controller.
package puf_ec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StCollect,
    StDone
  } ec_state_e;

  function automatic int unsigned ec_words(int unsigned n, int unsigned bits);
    return n / bits;
  endfunction

  function automatic int unsigned ec_weight_w(int unsigned nblk, int unsigned n);
    return $clog2(nblk * n + 1);
  endfunction

  function automatic int unsigned ec_tmo_w(int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ec_beat_popcount.sv
// Combinational population count of one decoder beat.
module ec_beat_popcount
  import puf_ec_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned CntW = $clog2(BITS + 1)
) (
  input  logic [BITS-1:0] beat_i,
  output logic [CntW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < BITS; i++) begin
      count_o = count_o + CntW'(beat_i[i]);
    end
  end

endmodule

// File: rtl/puf_ec_ctrl.sv
// Error-correction controller: streams NBLK (response ^ helper) codewords to an external
// BCH decoder, collects the returned error pattern and applies it to the response.
module puf_ec_ctrl
  import puf_ec_pkg::*;
#(
  parameter int unsigned N       = 264,
  parameter int unsigned BITS    = 8,
  parameter int unsigned NBLK    = 1,
  parameter int unsigned T       = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NBLK*N-1:0]                  helper,
  input  logic [NBLK*N-1:0]                  response,
  output logic                               busy,
  output logic                               ready,
  output logic [NBLK*N-1:0]                  corrected,
  output logic [NBLK*N-1:0]                  err_pattern,
  output logic [ec_weight_w(NBLK, N)-1:0]    err_weight,
  output logic                               errors,
  output logic                               fail,
  output logic [BITS-1:0]                    dec_data,
  output logic                               dec_start,
  input  logic [BITS-1:0]                    dec_err,
  input  logic                               dec_first
);

  localparam int unsigned Words = ec_words(N, BITS);
  localparam int unsigned TotW  = NBLK * N;
  localparam int unsigned WgtW  = ec_weight_w(NBLK, N);
  localparam int unsigned TmoW  = ec_tmo_w(TIMEOUT);
  localparam int unsigned BeatW = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned BlkW  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned PopW  = $clog2(BITS + 1);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Words - 1);
  localparam logic [BlkW-1:0]  LastBlk  = BlkW'(NBLK - 1);
  localparam logic [TmoW-1:0]  TmoMax   = TmoW'(TIMEOUT);

  if (N % BITS != 0) begin : g_bad_n
    $error("puf_ec_ctrl: N must be a multiple of BITS");
  end
  if (NBLK < 1) begin : g_bad_nblk
    $error("puf_ec_ctrl: NBLK must be at least 1");
  end

  ec_state_e        state_q, state_d;
  logic [BlkW-1:0]  blk_q, blk_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [TotW-1:0]  resp_q, resp_d;
  logic [TotW-1:0]  xr_q, xr_d;
  logic [TotW-1:0]  pat_q, pat_d;
  logic [WgtW-1:0]  blk_wt_q, blk_wt_d;
  logic [WgtW-1:0]  tot_wt_q, tot_wt_d;
  logic             fail_q, fail_d;
  logic [TotW-1:0]  corrected_q, corrected_d;
  logic [TotW-1:0]  err_pattern_q, err_pattern_d;
  logic [WgtW-1:0]  err_weight_q, err_weight_d;
  logic             errors_q, errors_d;
  logic             fail_out_q, fail_out_d;

  logic             capture;
  logic             last_beat;
  logic [PopW-1:0]  pop_cnt;

  ec_beat_popcount #(
    .BITS(BITS)
  ) u_popcount (
    .beat_i (dec_err),
    .count_o(pop_cnt)
  );

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    resp_d        = resp_q;
    xr_d          = xr_q;
    pat_d         = pat_q;
    blk_wt_d      = blk_wt_q;
    tot_wt_d      = tot_wt_q;
    fail_d        = fail_q;
    corrected_d   = corrected_q;
    err_pattern_d = err_pattern_q;
    err_weight_d  = err_weight_q;
    errors_d      = errors_q;
    fail_out_d    = fail_out_q;
    capture       = 1'b0;
    last_beat     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          resp_d   = response;
          xr_d     = response ^ helper;
          pat_d    = '0;
          blk_wt_d = '0;
          tot_wt_d = '0;
          fail_d   = 1'b0;
          blk_d    = '0;
          beat_d   = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        // The transmit shifter keeps the next beat in the low bits.
        xr_d = xr_q >> BITS;
        if (beat_q == LastBeat) begin
          beat_d  = '0;
          tmo_d   = '0;
          state_d = StWait;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StWait: begin
        if (dec_first) begin
          capture   = 1'b1;
          last_beat = (Words == 1);
        end else if (tmo_q == TmoMax) begin
          // Collected blocks sit at the top of pat_q; uncollected blocks read as zero.
          pat_d   = pat_q >> ((NBLK - 32'(blk_q)) * N);
          fail_d  = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCollect: begin
        capture   = 1'b1;
        last_beat = (beat_q == LastBeat);
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (capture) begin
      pat_d = pat_q >> BITS;
      pat_d[TotW-1 -: BITS] = dec_err;
      blk_wt_d = ((state_q == StWait) ? WgtW'(0) : blk_wt_q) + WgtW'(pop_cnt);
      tot_wt_d = tot_wt_q + WgtW'(pop_cnt);
      if (last_beat) begin
        beat_d = '0;
        if (32'(blk_wt_d) > T) begin
          fail_d = 1'b1;
        end
        if (blk_q != LastBlk) begin
          blk_d   = blk_q + BlkW'(1);
          state_d = StSend;
        end else begin
          state_d = StDone;
        end
      end else begin
        beat_d  = beat_q + BeatW'(1);
        state_d = StCollect;
      end
    end

    // Results become visible together in the ready cycle.
    if (state_d == StDone) begin
      corrected_d   = resp_q ^ pat_d;
      err_pattern_d = pat_d;
      err_weight_d  = tot_wt_d;
      errors_d      = (tot_wt_d != '0);
      fail_out_d    = fail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      blk_q         <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      resp_q        <= '0;
      xr_q          <= '0;
      pat_q         <= '0;
      blk_wt_q      <= '0;
      tot_wt_q      <= '0;
      fail_q        <= 1'b0;
      corrected_q   <= '0;
      err_pattern_q <= '0;
      err_weight_q  <= '0;
      errors_q      <= 1'b0;
      fail_out_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      resp_q        <= resp_d;
      xr_q          <= xr_d;
      pat_q         <= pat_d;
      blk_wt_q      <= blk_wt_d;
      tot_wt_q      <= tot_wt_d;
      fail_q        <= fail_d;
      corrected_q   <= corrected_d;
      err_pattern_q <= err_pattern_d;
      err_weight_q  <= err_weight_d;
      errors_q      <= errors_d;
      fail_out_q    <= fail_out_d;
    end
  end

  assign busy        = (state_q == StSend) || (state_q == StWait) || (state_q == StCollect);
  assign ready       = (state_q == StDone);
  assign dec_data    = (state_q == StSend) ? xr_q[BITS-1:0] : '0;
  assign dec_start   = (state_q == StSend) && (beat_q == '0);
  assign corrected   = corrected_q;
  assign err_pattern = err_pattern_q;
  assign err_weight  = err_weight_q;
  assign errors      = errors_q;
  assign fail        = fail_out_q;

endmodule
